hr_bridge_fifo: RTL and testbench



---
 rtl/hr_bridge_fifo_if.sv | 26 ++
 rtl/hr_bridge_fifo.sv | 75 +++++++
 tb/tb_hr_bridge_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hr_bridge_fifo_if.sv
// Bridge-port bundle between the hierarchical-ring bridge (master) and its
// per-port transfer buffer (slave). Signal names follow the buffer's view.
interface hr_bridge_fifo_if #(
  parameter int WIDTH = 144,
  parameter int AW    = 2
);
  logic             enQ_i;
  logic [WIDTH-1:0] data_i;
  logic             deQ_i;
  logic [WIDTH-1:0] data_o;
  logic             bfull_o;
  logic             empty_o;
  logic [AW:0]      cnt_o;
  logic             ovf_o;
  logic             udf_o;

  modport master (
    output enQ_i, data_i, deQ_i,
    input  data_o, bfull_o, empty_o, cnt_o, ovf_o, udf_o
  );

  modport slave (
    input  enQ_i, data_i, deQ_i,
    output data_o, bfull_o, empty_o, cnt_o, ovf_o, udf_o
  );
endinterface

// File: rtl/hr_bridge_fifo.sv
// Per-port circular flit buffer for the hierarchical-ring bridge: zero flit
// when empty, occupancy count, and sticky overflow/underflow flags.
module hr_bridge_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  hr_bridge_fifo_if.slave  bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wp_q, wp_d;
  logic [AW-1:0]               rp_q, rp_d;
  logic [AW:0]                 cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;
  logic                        udf_q, udf_d;

  logic full, empty, push_ok, pop_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  // A full buffer still takes a push when the head leaves on the same edge.
  assign push_ok = bus.enQ_i && (!full || bus.deQ_i);
  assign pop_ok  = bus.deQ_i && !empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (push_ok) wp_d = wp_q + AW'(1);
    if (pop_ok)  rp_d = rp_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (bus.enQ_i && full && !bus.deQ_i) ovf_d = 1'b1;
    if (bus.deQ_i && empty)              udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Storage needs no reset; stale entries are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wp_q] <= bus.data_i;
  end

  assign bus.data_o  = empty ? '0 : mem_q[rp_q];
  assign bus.bfull_o = full;
  assign bus.empty_o = empty;
  assign bus.cnt_o   = cnt_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.udf_o   = udf_q;

endmodule

// File: tb/tb_hr_bridge_fifo.sv
// Directed bench for hr_bridge_fifo: queue-based model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_hr_bridge_fifo;
  localparam int WIDTH = 144;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hr_bridge_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  hr_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] flit(input logic [15:0] tag);
    return {128'h3C5A_0F1E_9B7D_2468_ACE0_1357_9BDF_0000, tag};
  endfunction

  // Model: queue of flits, sticky flags, applied on every rising edge.
  logic [WIDTH-1:0] mq[$];
  bit mvalid = 0, movf = 0, mudf = 0, seen_dead = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      movf = 0; mudf = 0; mvalid = 1;
    end else if (mvalid) begin
      bit f, e;
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      if (bus.enQ_i && f && !bus.deQ_i) movf = 1;
      if (bus.deQ_i && e) mudf = 1;
      if (bus.deQ_i && !e) void'(mq.pop_front());
      if (bus.enQ_i && (!f || bus.deQ_i)) mq.push_back(bus.data_i);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("m_data",  bus.data_o, (mq.size() != 0) ? mq[0] : '0);
      check("m_cnt",   WIDTH'(bus.cnt_o), WIDTH'(mq.size()));
      check("m_full",  WIDTH'(bus.bfull_o), WIDTH'(mq.size() == DEPTH));
      check("m_empty", WIDTH'(bus.empty_o), WIDTH'(mq.size() == 0));
      check("m_ovf",   WIDTH'(bus.ovf_o), WIDTH'(movf));
      check("m_udf",   WIDTH'(bus.udf_o), WIDTH'(mudf));
      if (bus.data_o === flit(16'hdead)) seen_dead = 1;
    end
  end

  // Inputs change just after a falling edge; state is inspected at the next one.
  task automatic step(input bit r, input bit e, input bit d, input logic [WIDTH-1:0] dat);
    rst = r; bus.enQ_i = e; bus.deQ_i = d; bus.data_i = dat;
    @(negedge clk);
  endtask

  initial begin
    bus.enQ_i = 1'b0; bus.deQ_i = 1'b0; bus.data_i = '0;
    @(negedge clk);

    // reset with push asserted
    step(1, 1, 0, flit(16'h185f));
    step(1, 1, 0, flit(16'h185f));
    check("rst_data",  bus.data_o, '0);
    check("rst_empty", WIDTH'(bus.empty_o), 1);
    check("rst_cnt",   WIDTH'(bus.cnt_o), 0);
    check("rst_full",  WIDTH'(bus.bfull_o), 0);
    check("rst_ovf",   WIDTH'(bus.ovf_o), 0);

    // fill
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, flit(16'h1850 + 16'(i)));
      check("fill_cnt", WIDTH'(bus.cnt_o), WIDTH'(i));
      check("fill_head", bus.data_o, flit(16'h1851));
    end
    check("fill_full", WIDTH'(bus.bfull_o), 1);

    // drain
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, '0);
      check("drain_head", bus.data_o, (i < 4) ? flit(16'h1851 + 16'(i)) : '0);
    end
    check("drain_empty", WIDTH'(bus.empty_o), 1);

    // overflow
    for (int i = 1; i <= 4; i++) step(0, 1, 0, flit(16'h1850 + 16'(i)));
    step(0, 1, 0, flit(16'hdead));
    check("ovf_cnt",  WIDTH'(bus.cnt_o), 4);
    check("ovf_head", bus.data_o, flit(16'h1851));
    check("ovf_flag", WIDTH'(bus.ovf_o), 1);

    // push+pop while full
    step(0, 1, 1, flit(16'h1855));
    check("pp_head", bus.data_o, flit(16'h1852));
    check("pp_cnt",  WIDTH'(bus.cnt_o), 4);
    check("pp_full", WIDTH'(bus.bfull_o), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, '0);
      check("pp_drain", bus.data_o, (i < 3) ? flit(16'h1853 + 16'(i)) : '0);
    end
    check("ovf_sticky", WIDTH'(bus.ovf_o), 1);
    check("no_dead", WIDTH'(seen_dead), 0);

    // underflow with simultaneous push
    step(0, 1, 1, flit(16'h185f));
    check("udf_flag", WIDTH'(bus.udf_o), 1);
    check("udf_cnt",  WIDTH'(bus.cnt_o), 1);
    check("udf_data", bus.data_o, flit(16'h185f));
    step(0, 0, 1, '0);
    check("udf_pop_empty", WIDTH'(bus.empty_o), 1);

    // alternating push/pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, flit(16'h2000 + 16'(i)));
      check("wrap_head", bus.data_o, flit(16'h2000 + 16'(i)));
      step(0, 0, 1, '0);
      check("wrap_empty", WIDTH'(bus.empty_o), 1);
    end

    // all-zero flit is stored like any other
    step(0, 1, 0, '0);
    check("zero_cnt",   WIDTH'(bus.cnt_o), 1);
    check("zero_empty", WIDTH'(bus.empty_o), 0);

    // mid-stream reset
    step(0, 1, 0, flit(16'h3001));
    step(0, 1, 0, flit(16'h3002));
    check("pre_rst_cnt", WIDTH'(bus.cnt_o), 3);
    step(1, 1, 1, flit(16'h3003));
    check("mrst_empty", WIDTH'(bus.empty_o), 1);
    check("mrst_data",  bus.data_o, '0);
    check("mrst_cnt",   WIDTH'(bus.cnt_o), 0);
    check("mrst_ovf",   WIDTH'(bus.ovf_o), 0);
    check("mrst_udf",   WIDTH'(bus.udf_o), 0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
